// File: rtl/adder_pkg.sv
// Shared constants and FSM state encoding for the chunked adder.
package adder_pkg;

    localparam int unsigned ADDER_WIDTH = 16;
    localparam int unsigned ADDER_CHUNK = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/adder_chunk.sv
// CHUNK-bit combinational ripple adder; also exposes the carry into its top bit
// so the caller can derive signed overflow on the most significant chunk.
module adder_chunk
    import adder_pkg::*;
#(
    parameter int unsigned CHUNK = ADDER_CHUNK
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             ci_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             co_o,
    output logic             ctop_o
);

    // Ripple the carry bit by bit, capturing the carry entering the top bit.
    always_comb begin
        logic c;
        c      = ci_i;
        sum_o  = '0;
        ctop_o = 1'b0;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) ctop_o = c;
            sum_o[i] = a_i[i] ^ b_i[i] ^ c;
            c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
        end
        co_o = c;
    end

endmodule

// File: rtl/adder_chunked.sv
// Multi-cycle adder: latches operands on start, then adds one CHUNK-bit slice
// per clock through a single shared adder_chunk, pulsing done when finished.
module adder_chunked
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = ADDER_WIDTH,
    parameter int unsigned CHUNK = ADDER_CHUNK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] r1,
    input  logic [WIDTH-1:0] r2,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = $clog2(NCHUNK + 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  op1_q, op1_d;
    logic [WIDTH-1:0]  op2_q, op2_d;
    logic              rc_q, rc_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              carry_q, carry_d;
    logic              ovf_q, ovf_d;

    logic [WIDTH-1:0]  op1_sh, op2_sh;
    logic [CHUNK-1:0]  sum_chunk;
    logic              co_chunk, ctop_chunk;

    // Bring the current chunk down to bit 0; a shift keeps an out-of-range index harmless.
    always_comb begin
        op1_sh = op1_q >> (CHUNK * idx_q);
        op2_sh = op2_q >> (CHUNK * idx_q);
    end

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a_i    (op1_sh[CHUNK-1:0]),
        .b_i    (op2_sh[CHUNK-1:0]),
        .ci_i   (rc_q),
        .sum_o  (sum_chunk),
        .co_o   (co_chunk),
        .ctop_o (ctop_chunk)
    );

    // Next-state and datapath update: accept in IDLE/DONE, one chunk per RUN cycle.
    always_comb begin
        state_d  = state_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        rc_d     = rc_q;
        idx_d    = idx_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = RUN;
                    op1_d    = r1;
                    op2_d    = r2;
                    rc_d     = ci;
                    idx_d    = '0;
                    result_d = '0;
                    carry_d  = 1'b0;
                    ovf_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                for (int unsigned k = 0; k < NCHUNK; k++) begin
                    if (idx_q == IDXW'(k)) result_d[k*CHUNK +: CHUNK] = sum_chunk;
                end
                rc_d  = co_chunk;
                idx_d = idx_q + IDXW'(1);
                if (idx_q == IDXW'(NCHUNK - 1)) begin
                    state_d = DONE;
                    carry_d = co_chunk;
                    ovf_d   = co_chunk ^ ctop_chunk;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset taking priority over start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op1_q    <= '0;
            op2_q    <= '0;
            rc_q     <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            rc_q     <= rc_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign result   = result_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_adder_chunked.sv
// Self-checking bench: four 16-bit instances (CHUNK 1,2,4,16) share stimulus and
// are tracked by a cycle model with per-instance scoreboards; an 8-bit/8-bit
// instance covers the single-chunk corner.
module tb_adder_chunked;

    typedef struct packed {
        logic [15:0] res;
        logic        cy;
        logic        ov;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, start, ci;
    logic [15:0] r1, r2;
    logic [3:0]  busy_v, done_v, cy_v, ov_v;
    logic [15:0] res_v [4];

    logic        st8, ci8, busy8, done8, cy8, ov8;
    logic [7:0]  a8, b8, res8;

    int   checks = 0;
    int   errors = 0;
    exp_t sb [4][$];
    int   left [4];
    logic dexp [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned CHG = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16;
        adder_chunked #(.WIDTH(16), .CHUNK(CHG)) u_dut (
            .clk      (clk),
            .reset    (reset),
            .start    (start),
            .r1       (r1),
            .r2       (r2),
            .ci       (ci),
            .busy     (busy_v[g]),
            .done     (done_v[g]),
            .result   (res_v[g]),
            .carry    (cy_v[g]),
            .overflow (ov_v[g])
        );
    end

    adder_chunked #(.WIDTH(8), .CHUNK(8)) u_dut8 (
        .clk      (clk),
        .reset    (reset),
        .start    (st8),
        .r1       (a8),
        .r2       (b8),
        .ci       (ci8),
        .busy     (busy8),
        .done     (done8),
        .result   (res8),
        .carry    (cy8),
        .overflow (ov8)
    );

    function automatic exp_t ref_add(input logic [15:0] a, input logic [15:0] b, input logic c);
        logic [16:0] s;
        exp_t        e;
        s    = {1'b0, a} + {1'b0, b} + {16'b0, c};
        e.res = s[15:0];
        e.cy  = s[16];
        e.ov  = (a[15] == b[15]) && (s[15] != a[15]);
        return e;
    endfunction

    function automatic int nch(input int i);
        case (i)
            0:       return 16;
            1:       return 8;
            2:       return 4;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // One clock: update the model at the rising edge, compare at the falling edge.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                left[i] = 0;
                dexp[i] = 1'b0;
                sb[i].delete();
            end else if (left[i] > 0) begin
                left[i]--;
                dexp[i] = (left[i] == 0);
            end else begin
                dexp[i] = 1'b0;
                if (start) begin
                    left[i] = nch(i);
                    sb[i].push_back(ref_add(r1, r2, ci));
                end
            end
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("busy%0d", i), {31'b0, busy_v[i]}, {31'b0, left[i] > 0});
            chk($sformatf("done%0d", i), {31'b0, done_v[i]}, {31'b0, dexp[i]});
            if (done_v[i] === 1'b1) begin
                if (sb[i].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow%0d actual=done required=no_done", i);
                end else begin
                    e = sb[i].pop_front();
                    chk($sformatf("sum%0d", i), {14'b0, res_v[i], cy_v[i], ov_v[i]}, {14'b0, e});
                end
            end
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (done_v[2] !== 1'b1 && n < 40);
        if (done_v[2] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=%0d_cycles required=done", n);
        end
    endtask

    task automatic pulse(input logic [15:0] a, input logic [15:0] b, input logic c);
        r1    = a;
        r2    = b;
        ci    = c;
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) cycle();
    endtask

    initial begin
        vec_t tbl [8];
        int   n;

        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0}};
        tbl[1] = '{16'h1234, 16'h4321, 1'b1, '{16'h5556, 1'b0, 1'b0}};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1}};
        tbl[3] = '{16'h8000, 16'h8000, 1'b0, '{16'h0000, 1'b1, 1'b1}};
        tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1, '{16'hFFFF, 1'b1, 1'b0}};
        tbl[5] = '{16'h0000, 16'h0000, 1'b1, '{16'h0001, 1'b0, 1'b0}};
        tbl[6] = '{16'h0F0F, 16'h00F1, 1'b0, '{16'h1000, 1'b0, 1'b0}};
        tbl[7] = '{16'h8000, 16'hFFFF, 1'b0, '{16'h7FFF, 1'b1, 1'b1}};

        reset = 1'b1; start = 1'b0; r1 = '0; r2 = '0; ci = 1'b0;
        st8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
        cycle();
        cycle();
        chk("rst_busy", {28'b0, busy_v}, 32'h0);
        chk("rst_done", {28'b0, done_v}, 32'h0);
        chk("rst_out", {14'b0, res_v[2], cy_v[2], ov_v[2]}, 32'h0);
        chk("rst_out8", {21'b0, res8, cy8, ov8, busy8, done8}, 32'h0);
        reset = 1'b0;

        // Table vectors; operands are scrambled right after acceptance.
        for (int k = 0; k < 8; k++) begin
            pulse(tbl[k].a, tbl[k].b, tbl[k].c);
            r1 = 16'($urandom);
            r2 = 16'($urandom);
            ci = ~ci;
            wait_done(n);
            chk($sformatf("lat%0d", k), n, 32'd4);
            chk($sformatf("tbl%0d", k), {14'b0, res_v[2], cy_v[2], ov_v[2]}, {14'b0, tbl[k].e});
            drain(18);
        end

        // Partial result after two chunks, then reset aborts the addition.
        pulse(16'h1234, 16'h4321, 1'b1);
        cycle();
        cycle();
        chk("partial", {16'b0, res_v[2]}, 32'h0056);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("abort_busy", {31'b0, busy_v[2]}, 32'h0);
        chk("abort_out", {14'b0, res_v[2], cy_v[2], ov_v[2]}, 32'h0);
        drain(8);
        reset = 1'b1;
        start = 1'b1;
        cycle();
        reset = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", {28'b0, busy_v}, 32'h0);
        pulse(16'hFFFF, 16'h0001, 1'b0);
        wait_done(n);
        chk("after_abort", {14'b0, res_v[2], cy_v[2], ov_v[2]}, {14'b0, 16'h0000, 1'b1, 1'b0});
        drain(18);

        // Start re-pulsed during RUN is ignored.
        pulse(16'h7FFF, 16'h0001, 1'b0);
        cycle();
        cycle();
        pulse(16'h1111, 16'h1111, 1'b0);
        wait_done(n);
        chk("repulse", {14'b0, res_v[2], cy_v[2], ov_v[2]}, {14'b0, 16'h8000, 1'b0, 1'b1});
        drain(18);

        // Start held through DONE launches a back-to-back addition.
        r1 = 16'h0F0F; r2 = 16'h00F1; ci = 1'b0; start = 1'b1;
        cycle();
        r1 = 16'h8000; r2 = 16'hFFFF;
        wait_done(n);
        chk("held_first", {14'b0, res_v[2], cy_v[2], ov_v[2]}, {14'b0, 16'h1000, 1'b0, 1'b0});
        cycle();
        start = 1'b0;
        chk("held_busy", {31'b0, busy_v[2]}, 32'h1);
        wait_done(n);
        chk("held_lat", n, 32'd4);
        chk("held_second", {14'b0, res_v[2], cy_v[2], ov_v[2]}, {14'b0, 16'h7FFF, 1'b1, 1'b1});
        drain(20);

        // Single-chunk instance: done one cycle after acceptance.
        a8 = 8'h80; b8 = 8'h80; ci8 = 1'b0; st8 = 1'b1;
        cycle();
        st8 = 1'b0;
        chk("w8_run", {30'b0, busy8, done8}, 32'h2);
        cycle();
        chk("w8_done", {22'b0, done8, res8, cy8, ov8}, {22'b0, 1'b1, 8'h00, 1'b1, 1'b1});
        cycle();
        chk("w8_idle", {30'b0, busy8, done8}, 32'h0);

        // Random traffic with occasional resets; the model checks every cycle.
        repeat (800) begin
            reset = ($urandom_range(0, 63) == 0);
            start = ($urandom_range(0, 2) == 0);
            r1    = 16'($urandom);
            r2    = 16'($urandom);
            ci    = 1'($urandom);
            cycle();
        end
        reset = 1'b0;
        start = 1'b0;
        drain(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
